// File: rtl/dram_req_arbiter.sv
// Two-requester arbiter/sequencer for a single-outstanding DRAM AXI slave port.
// Latency: req sampled in IDLE -> AR/AW valid next cycle; gnt earliest 2 cycles after req.
// Backpressure: valid held with stable addr/len/id until ready; no arbitration while busy.
//
// Ports: clk/rst (sync, active-high); req/we/addr/len/gnt per requester;
//        AR*/AW* address channels to the slave; R/B handshakes observed for completion;
//        owner steers external W/R data, busy spans grant decision to completion.
// Optional feature: define DRAM_ARB_AGING_EN to enable starvation-avoidance age counters.
module dram_req_arbiter #(
  parameter int ROW_HI  = 22,
  parameter int ROW_LO  = 12,
  parameter int AGE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [3:0]  len0,
  output logic        gnt0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [3:0]  len1,
  output logic        gnt1,
  output logic        ARVALID_M,
  output logic [31:0] ARADDR_M,
  output logic [3:0]  ARLEN_M,
  output logic [7:0]  ARID_M,
  input  logic        ARREADY_M,
  output logic        AWVALID_M,
  output logic [31:0] AWADDR_M,
  output logic [3:0]  AWLEN_M,
  output logic [7:0]  AWID_M,
  input  logic        AWREADY_M,
  input  logic        RVALID_M,
  input  logic        RREADY_M,
  input  logic        RLAST_M,
  input  logic        BVALID_M,
  input  logic        BREADY_M,
  output logic        owner,
  output logic        busy
);

  localparam int ROW_W = ROW_HI - ROW_LO + 1;

  typedef enum logic [1:0] {IDLE, ADDR, RWAIT, BWAIT} state_t;

  state_t             state, state_nxt;
  logic               cmd_we;
  logic [31:0]        cmd_addr;
  logic [3:0]         cmd_len;
  logic               rr;
  logic               row_valid;
  logic [ROW_W-1:0]   last_row;

  logic               any_req;
  logic               both_req;
  logic               hit0, hit1;
  logic               win_both;
  logic               win;
  logic               addr_hs;
  logic               done;

  assign any_req  = req0 | req1;
  assign both_req = req0 & req1;

  // Row hit only counts once a row has actually been opened since reset.
  assign hit0 = row_valid && (addr0[ROW_HI:ROW_LO] == last_row);
  assign hit1 = row_valid && (addr1[ROW_HI:ROW_LO] == last_row);

`ifdef DRAM_ARB_AGING_EN
  logic [2:0] age0, age1;
  logic       old0, old1;

  assign old0 = (age0 == 3'(AGE_MAX));
  assign old1 = (age1 == 3'(AGE_MAX));

  // A starved requester overrides row-hit and rr; if both starved, rr breaks the tie.
  always_comb begin
    win_both = rr;
    if (old0 ^ old1)      win_both = old1;
    else if (!old0 && (hit0 ^ hit1)) win_both = hit1;
  end
`else
  always_comb begin
    win_both = rr;
    if (hit0 ^ hit1) win_both = hit1;
  end
`endif

  // With a single requester it wins outright; only contention consults hit/rr.
  assign win = both_req ? win_both : req1;

  assign addr_hs = (state == ADDR) && (cmd_we ? AWREADY_M : ARREADY_M);
  assign done    = ((state == RWAIT) && RVALID_M && RREADY_M && RLAST_M) ||
                   ((state == BWAIT) && BVALID_M && BREADY_M);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ADDR;
      ADDR:    if (addr_hs) state_nxt = cmd_we ? BWAIT : RWAIT;
      RWAIT:   if (done)    state_nxt = IDLE;
      BWAIT:   if (done)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      owner     <= 1'b0;
      busy      <= 1'b0;
      rr        <= 1'b0;
      row_valid <= 1'b0;
      last_row  <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && any_req) begin
        cmd_we   <= win ? we1   : we0;
        cmd_addr <= win ? addr1 : addr0;
        cmd_len  <= win ? len1  : len0;
        owner    <= win;
        busy     <= 1'b1;
      end
      if (addr_hs) begin
        last_row  <= cmd_addr[ROW_HI:ROW_LO];
        row_valid <= 1'b1;
        rr        <= ~owner;
      end
      if (done) busy <= 1'b0;
    end
  end

`ifdef DRAM_ARB_AGING_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      age0 <= '0;
      age1 <= '0;
    end else if ((state == IDLE) && any_req) begin
      if (win) begin
        age1 <= '0;
        if (req0 && !old0) age0 <= age0 + 3'd1;
      end else begin
        age0 <= '0;
        if (req1 && !old1) age1 <= age1 + 3'd1;
      end
    end
  end
`endif

  assign ARVALID_M = (state == ADDR) && !cmd_we;
  assign AWVALID_M = (state == ADDR) &&  cmd_we;
  assign ARADDR_M  = cmd_addr;
  assign AWADDR_M  = cmd_addr;
  assign ARLEN_M   = cmd_len;
  assign AWLEN_M   = cmd_len;
  assign ARID_M    = {7'b0, owner};
  assign AWID_M    = {7'b0, owner};
  assign gnt0      = addr_hs && !owner;
  assign gnt1      = addr_hs &&  owner;

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Self-checking bench for dram_req_arbiter: directed transactions with literal
// expectations plus a transaction-phase model compared against the DUT every cycle.
module tb_dram_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0;
  logic [3:0]  len0 = 0, len1 = 0;
  logic        gnt0, gnt1;
  logic        ARVALID_M, AWVALID_M;
  logic [31:0] ARADDR_M, AWADDR_M;
  logic [3:0]  ARLEN_M, AWLEN_M;
  logic [7:0]  ARID_M, AWID_M;
  logic        ARREADY_M = 0, AWREADY_M = 0;
  logic        RVALID_M = 0, RREADY_M = 0, RLAST_M = 0, BVALID_M = 0, BREADY_M = 0;
  logic        owner, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dram_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .len0(len0), .gnt0(gnt0),
    .req1(req1), .we1(we1), .addr1(addr1), .len1(len1), .gnt1(gnt1),
    .ARVALID_M(ARVALID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARID_M(ARID_M),
    .ARREADY_M(ARREADY_M),
    .AWVALID_M(AWVALID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWID_M(AWID_M),
    .AWREADY_M(AWREADY_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M), .RLAST_M(RLAST_M),
    .BVALID_M(BVALID_M), .BREADY_M(BREADY_M),
    .owner(owner), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Phase of the one outstanding transaction: 0 none, 1 address offered,
  // 2 waiting for last read beat, 3 waiting for write response.
  logic        m_init = 1'b0;
  int          m_ph = 0;
  logic        m_we = 0, m_owner = 0, m_busy = 0, m_rr = 0, m_rv = 0;
  logic [31:0] m_addr = 0;
  logic [3:0]  m_len = 0;
  logic [10:0] m_row = 0;
  int          m_age[2] = '{0, 0};

  function automatic logic pick();
    logic h0, h1;
    if (req0 && !req1) return 1'b0;
    if (req1 && !req0) return 1'b1;
`ifdef DRAM_ARB_AGING_EN
    if (m_age[0] >= 4 && m_age[1] < 4) return 1'b0;
    if (m_age[1] >= 4 && m_age[0] < 4) return 1'b1;
`endif
    h0 = m_rv && (addr0[22:12] == m_row);
    h1 = m_rv && (addr1[22:12] == m_row);
    if (h0 && !h1) return 1'b0;
    if (h1 && !h0) return 1'b1;
    return m_rr;
  endfunction

  initial begin
    logic w, ar_v, aw_v, hs;
    forever begin
      @(negedge clk);
      if (m_init) begin
        ar_v = (m_ph == 1) && !m_we;
        aw_v = (m_ph == 1) && m_we;
        hs   = (ar_v && ARREADY_M) || (aw_v && AWREADY_M);
        chk("cyc_arvalid", ARVALID_M, ar_v);
        chk("cyc_awvalid", AWVALID_M, aw_v);
        chk("cyc_araddr",  ARADDR_M, m_addr);
        chk("cyc_awaddr",  AWADDR_M, m_addr);
        chk("cyc_arlen",   ARLEN_M, m_len);
        chk("cyc_awlen",   AWLEN_M, m_len);
        chk("cyc_arid",    ARID_M, m_owner);
        chk("cyc_awid",    AWID_M, m_owner);
        chk("cyc_gnt0",    gnt0, hs && !m_owner);
        chk("cyc_gnt1",    gnt1, hs && m_owner);
        chk("cyc_owner",   owner, m_owner);
        chk("cyc_busy",    busy, m_busy);
      end
      @(posedge clk);
      if (rst) begin
        m_init = 1; m_ph = 0; m_we = 0; m_addr = 0; m_len = 0; m_owner = 0;
        m_busy = 0; m_rr = 0; m_rv = 0; m_row = 0; m_age[0] = 0; m_age[1] = 0;
      end else if (m_init) begin
        case (m_ph)
          0: if (req0 || req1) begin
               w = pick();
               m_age[w] = 0;
               if ((w ? req0 : req1) && m_age[!w] < 4) m_age[!w]++;
               m_owner = w;
               m_we    = w ? we1 : we0;
               m_addr  = w ? addr1 : addr0;
               m_len   = w ? len1 : len0;
               m_busy  = 1;
               m_ph    = 1;
             end
          1: if (m_we ? AWREADY_M : ARREADY_M) begin
               m_row = m_addr[22:12];
               m_rv  = 1;
               m_rr  = !m_owner;
               m_ph  = m_we ? 3 : 2;
             end
          2: if (RVALID_M && RREADY_M && RLAST_M) begin m_ph = 0; m_busy = 0; end
          3: if (BVALID_M && BREADY_M) begin m_ph = 0; m_busy = 0; end
          default: m_ph = 0;
        endcase
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // One single-beat read arbitration; returns the granted requester (-1 on timeout).
  task automatic round(input logic r0, input logic r1, input logic [31:0] a0,
                       input logic [31:0] a1, output int win);
    req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
    we0 = 0; we1 = 0; len0 = 0; len1 = 0;
    win = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt0) begin win = 0; break; end
      if (gnt1) begin win = 1; break; end
    end
    if (win < 0) begin
      checks++; errors++;
      $display("FAIL round_timeout: got no grant expected a grant within 20 cycles");
    end else begin
      @(posedge clk); #1;
      RVALID_M = 1; RREADY_M = 1; RLAST_M = 1;
      @(posedge clk); #1;
      RVALID_M = 0; RREADY_M = 0; RLAST_M = 0;
    end
  endtask

  initial begin
    int n, w;
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_arvalid", ARVALID_M, 0);
    chk("rst_owner", owner, 0);
    rst = 0;

    // Single read, zero-wait address handshake, 4-beat burst.
    ARREADY_M = 1;
    req0 = 1; we0 = 0; addr0 = 32'h0000_3010; len0 = 4'd3;
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (gnt0) begin n = c; break; end
    end
    chk("rd_latency", n, 2);
    chk("rd_araddr", ARADDR_M, 32'h0000_3010);
    chk("rd_arlen", ARLEN_M, 3);
    chk("rd_arid", ARID_M, 0);
    chk("rd_awvalid", AWVALID_M, 0);
    @(posedge clk); #1;
    req0 = 0;
    for (int i = 0; i < 4; i++) begin
      RVALID_M = 1; RREADY_M = 1; RLAST_M = (i == 3);
      @(negedge clk);
      if (i == 3) chk("rd_busy_before_last", busy, 1);
      @(posedge clk); #1;
    end
    RVALID_M = 0; RREADY_M = 0; RLAST_M = 0;
    @(negedge clk);
    chk("rd_done_busy", busy, 0);

    // Write with the slave stalling the address for 3 cycles.
    ARREADY_M = 0; AWREADY_M = 0;
    @(posedge clk); #1;
    req1 = 1; we1 = 1; addr1 = 32'h0000_5000; len1 = 4'd0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr_awvalid_held", AWVALID_M, 1);
      chk("wr_awaddr_stable", AWADDR_M, 32'h0000_5000);
      chk("wr_no_gnt_yet", gnt1, 0);
      @(posedge clk); #1;
    end
    AWREADY_M = 1;
    @(negedge clk);
    chk("wr_gnt1", gnt1, 1);
    chk("wr_awid", AWID_M, 1);
    @(posedge clk); #1;
    req1 = 0; AWREADY_M = 0;
    repeat (2) begin
      @(negedge clk);
      chk("wr_busy_until_b", busy, 1);
    end
    BVALID_M = 1; BREADY_M = 1;
    @(posedge clk); #1;
    BVALID_M = 0; BREADY_M = 0;
    @(negedge clk);
    chk("wr_done_busy", busy, 0);
    chk("wr_owner_hold", owner, 1);

    // Row-hit priority: open row 0x003 via requester 1 (rr -> 0), then contend.
    ARREADY_M = 1; AWREADY_M = 1;
    @(posedge clk); #1;
    round(0, 1, 32'h0, 32'h0000_3000, w);       chk("prime_row3", w, 1);
    round(1, 1, 32'h0000_7000, 32'h0000_3100, w); chk("rowhit_first", w, 1);
    round(1, 0, 32'h0000_7000, 32'h0, w);       chk("rowhit_second", w, 0);

    // Round-robin: fresh rows every round so neither side hits; rr starts at 1.
    for (int i = 0; i < 4; i++) begin
      round(1, 1, 32'h0002_0000 + i * 32'h2000, 32'h0002_1000 + i * 32'h2000, w);
      chk("rr_alternate", w, (i % 2 == 0) ? 1 : 0);
    end

    // Starvation: requester 1 always hits the open row, requester 0 never does.
    round(0, 1, 32'h0, 32'h0004_0000, w); chk("prime_row40", w, 1);
    for (int i = 0; i < 6; i++) begin
      round(1, 1, 32'h0005_0000, 32'h0004_0100, w);
`ifdef DRAM_ARB_AGING_EN
      chk("aging_seq", w, (i < 4) ? 1 : 0);
`else
      chk("no_aging_seq", w, 1);
`endif
    end

    // Reset during a read burst by requester 1.
    req0 = 0; req1 = 1; we1 = 0; addr1 = 32'h0000_6000; len1 = 4'd2;
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (gnt1) begin n = c; break; end
    end
    chk("midrst_gnt_seen", n != 0, 1);
    @(posedge clk); #1;
    req1 = 0;
    RVALID_M = 1; RREADY_M = 1; RLAST_M = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; RVALID_M = 0; RREADY_M = 0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_owner", owner, 0);
    chk("midrst_arvalid", ARVALID_M, 0);
    chk("midrst_araddr", ARADDR_M, 0);
    // A stale open row would make requester 1 win here; after reset rr=0 decides.
    round(1, 1, 32'h0000_8000, 32'h0000_6000, w); chk("post_rst_arb", w, 0);

    req0 = 0; req1 = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
